reg_dump_scanner: RTL
=====================

// Module: reg_dump_scanner
// PURPOSE
//   Continuously dumps the register file onto the VGA text screen as 8-digit hex words.
//   Reads one register at a time, then emits its nibbles MSB-first with a text-RAM
//   write address per digit. Sits between the RISC-V register-file debug read port and
//   the hex-digit-to-ASCII converter.
//   The parent wires `nibble` through the converter to the text-RAM write data.
// PARAMETERS
//   NREGS   32   registers scanned per frame (indices 0..NREGS-1)
//   COLS    80   text columns per screen row
//   ROW0    0    screen row that shows register 0
//   COL0    4    screen column of the most-significant digit
//   ADDR_W  12   text-RAM address width; must hold (ROW0+NREGS-1)*COLS+COL0+7
// PORTS
//   clk         in   1       system clock
//   rst_n       in   1       asynchronous active-low reset
//   enable      in   1       level; 1 = keep scanning frames
//   rf_addr     out  5       register-file debug read address
//   rf_data     in   32      register-file read data, valid 1 cycle after rf_addr
//   nibble      out  4       current hex digit, to the nibble-to-ASCII converter
//   wr_en       out  1       text-RAM write strobe
//   wr_addr     out  ADDR_W  text-RAM write address
//   wr_ready    in   1       text-RAM arbiter accepts the write this cycle
//   busy        out  1       1 whenever state != IDLE
//   frame_done  out  1       1-cycle pulse after the last register of a frame
// BEHAVIOUR
//   Reset (async, immediate, also mid-operation): state=IDLE, reg_idx=0, digit=0,
//     shift reg=0; outputs rf_addr=0, nibble=0, wr_en=0, wr_addr=0, busy=0, frame_done=0.
//   FSM (Moore, all outputs decoded from registers):
//     IDLE  : enable=1 -> FETCH.
//     FETCH : rf_addr=reg_idx -> LATCH.
//     LATCH : shreg<=rf_data, digit<=0 -> EMIT.
//     EMIT  : wr_en=1, nibble=shreg[31:28], wr_addr=(ROW0+reg_idx)*COLS+COL0+digit.
//             On wr_ready=1: shreg<<=4, digit++; digit==7 -> NEXT.
//             On wr_ready=0: hold nibble and wr_addr stable (no loss, no duplicate).
//     NEXT  : if reg_idx==NREGS-1: reg_idx<=0, frame_done=1; else reg_idx++.
//             Then enable=1 -> FETCH, else -> IDLE.
//   rf_addr holds reg_idx in all states.
//   Latency with wr_ready held 1: 11 cycles per register (1+1+8+1);
//     NREGS*11 cycles per frame (352 at default).
//   Address arithmetic: unsigned, evaluated in ADDR_W bits; parameters are chosen so
//     the address never overflows, so no wrap is handled.
//   enable dropped mid-register: the current register is finished (all 8 digits),
//     then IDLE.
//   enable dropped mid-frame: reg_idx is retained, and the next enable resumes at
//     that register.
//   enable re-asserted while in NEXT: the scan continues without passing through IDLE.
//   Back-pressure: wr_ready may be low for any number of cycles; EMIT stalls,
//     with no timeout.
//   rf_data is sampled only in LATCH; register changes during EMIT do not affect
//     the digits in flight.
// STRUCTURE
//   Shared header vga_text_defs.vh holds TEXT_COLS=80, TEXT_ROWS=30, TEXT_ADDR_W=12
//     and the state encodings (IDLE=0, FETCH=1, LATCH=2, EMIT=3, NEXT=4, 3-bit).
//   Single module, no sub-module.
//   The nibble-to-ASCII converter is instantiated by the parent, not inside this block.
// TESTING
//   1. Reset then enable=1, regs x1=32'h1234ABCD, wr_ready=1 ->
//      row-1 writes: addr 84..91, nibbles 1,2,3,4,A,B,C,D, on consecutive cycles.
//   2. x0=0, full frame with wr_ready=1 -> frame_done pulses exactly once at cycle 352;
//      the scan restarts with rf_addr=0.
//   3. wr_ready low for 5 cycles on digit 3 of 32'hDEADBEEF -> nibble=D and wr_addr
//      held for 5 cycles; exactly 8 accepted writes; no duplicate.
//   4. Drop enable during digit 2 of reg 5 -> digits 2..7 still written, then IDLE
//      with busy=0; re-enable -> first FETCH shows rf_addr=6.
//   5. Assert rst_n=0 during EMIT -> wr_en=0 and busy=0 immediately (asynchronously);
//      after release and enable, the scan restarts at reg 0 / addr 4.
//   6. Change rf_data for the register being emitted after LATCH -> written digits
//      match the latched value only.

Source files
------------

// File: rtl/reg_dump_scanner_pkg.sv
// Shared text-screen geometry and scanner state encodings for the register dump block.
package reg_dump_scanner_pkg;

    localparam int unsigned TEXT_COLS   = 80;
    localparam int unsigned TEXT_ROWS   = 30;
    localparam int unsigned TEXT_ADDR_W = 12;

    localparam logic [2:0] LAST_DIGIT = 3'd7;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StLatch = 3'd2,
        StEmit  = 3'd3,
        StNext  = 3'd4
    } state_e;

endpackage

// File: rtl/reg_dump_scanner.sv
// Scans the register file and writes each register as 8 hex digits, MSB first,
// into consecutive text-RAM cells of the register's screen row.
module reg_dump_scanner
    import reg_dump_scanner_pkg::*;
#(
    parameter int unsigned NREGS  = 32,
    parameter int unsigned COLS   = TEXT_COLS,
    parameter int unsigned ROW0   = 0,
    parameter int unsigned COL0   = 4,
    parameter int unsigned ADDR_W = TEXT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic [4:0]        rf_addr,
    input  logic [31:0]       rf_data,
    output logic [3:0]        nibble,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ready,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [4:0] LAST_REG = 5'(NREGS - 1);

    state_e      r_state;
    state_e      w_state_next;
    logic [4:0]  r_reg_idx;
    logic [4:0]  w_reg_idx_next;
    logic [2:0]  r_digit;
    logic [2:0]  w_digit_next;
    logic [31:0] r_shreg;
    logic [31:0] w_shreg_next;

    logic [ADDR_W-1:0] w_row;
    logic [ADDR_W-1:0] w_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_reg_idx <= '0;
            r_digit   <= '0;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_reg_idx <= w_reg_idx_next;
            r_digit   <= w_digit_next;
            r_shreg   <= w_shreg_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_reg_idx_next = r_reg_idx;
        w_digit_next   = r_digit;
        w_shreg_next   = r_shreg;
        unique case (r_state)
            StIdle: begin
                if (enable) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                w_state_next = StLatch;
            end
            StLatch: begin
                // rf_data only becomes valid one cycle after rf_addr, so sample here.
                w_shreg_next = rf_data;
                w_digit_next = '0;
                w_state_next = StEmit;
            end
            StEmit: begin
                if (wr_ready) begin
                    w_shreg_next = {r_shreg[27:0], 4'h0};
                    w_digit_next = r_digit + 3'd1;
                    if (r_digit == LAST_DIGIT) begin
                        w_state_next = StNext;
                    end
                end
            end
            StNext: begin
                if (r_reg_idx == LAST_REG) begin
                    w_reg_idx_next = '0;
                end else begin
                    w_reg_idx_next = r_reg_idx + 5'd1;
                end
                w_state_next = enable ? StFetch : StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Parameters guarantee the row/column arithmetic fits ADDR_W, so no wrap handling.
    assign w_row  = ADDR_W'(ROW0) + ADDR_W'(r_reg_idx);
    assign w_addr = w_row * ADDR_W'(COLS) + ADDR_W'(COL0) + ADDR_W'(r_digit);

    assign rf_addr    = r_reg_idx;
    assign nibble     = r_shreg[31:28];
    assign wr_en      = (r_state == StEmit);
    assign wr_addr    = wr_en ? w_addr : '0;
    assign busy       = (r_state != StIdle);
    assign frame_done = (r_state == StNext) && (r_reg_idx == LAST_REG);

endmodule
